ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- Execute-stage wrapper around the core ALU: ID->EX register, operand forwarding/selection, ALU drive, and EX->MEM result register.
- Accepts decoded instructions from decode and presents the opcode plus the two resolved operands to the ALU.
- Captures the ALU result, zero flag and branch outcome into a registered output for the memory stage.
- Detects load-use hazards and inserts one bubble.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous kill of every in-flight instruction in this block.
- id_valid_i  in  1  decode presents an instruction.
- id_ready_o  out  1  this stage accepts the instruction.
- id_alu_op_i  in  4  ALU opcode.
- id_rs1_val_i, id_rs2_val_i  in  XLEN  register-file read data.
- id_rs1_idx_i, id_rs2_idx_i  in  REG_ADDR_W  source indices.
- id_rd_idx_i  in  REG_ADDR_W  destination index.
- id_rd_we_i  in  1  instruction writes rd.
- id_imm_i  in  XLEN  sign-extended immediate.
- id_pc_i  in  XLEN  instruction PC.
- id_sel_a_pc_i  in  1  operand A = PC (else rs1).
- id_sel_b_imm_i  in  1  operand B = imm (else rs2).
- id_is_load_i  in  1  load instruction.
- id_is_branch_i  in  1  conditional branch.
- id_br_inv_i  in  1  branch taken on ZR=0 (else on ZR=1).
- alu_op_o  out  4  to the ALU opcode input.
- alu_a_o, alu_b_o  out  XLEN  to the ALU operand inputs.
- alu_rd_i  in  XLEN  ALU result.
- alu_zr_i  in  1  ALU zero flag.
- wb_we_i  in  1  writeback valid and write-enabled.
- wb_idx_i  in  REG_ADDR_W  writeback index.
- wb_data_i  in  XLEN  writeback data.
- mem_valid_o  out  1  registered result valid.
- mem_ready_i  in  1  memory stage accepts the result.
- mem_result_o  out  XLEN  registered ALU result.
- mem_store_data_o  out  XLEN  forwarded rs2 value.
- mem_rd_idx_o  out  REG_ADDR_W  registered destination index.
- mem_rd_we_o  out  1  registered write enable.
- mem_is_load_o  out  1  registered load flag.
- redirect_valid_o  out  1  registered branch-taken pulse.
- redirect_pc_o  out  XLEN  registered branch target, PC+imm, mod 2^XLEN.

Behaviour:
- Reset: all valid bits, mem_valid_o, redirect_valid_o, mem_rd_we_o and mem_is_load_o go to 0; all data registers go to 0; id_ready_o=1.
- Register A (ID->EX) holds valid_a plus all id_* fields.
- Register B (EX->MEM) drives every mem_* output and both redirect_* outputs.
- Forwarding, per source, with priority order:
  - idx==0 gives 0.
  - Else register B, when mem_valid_o & mem_rd_we_o & !mem_is_load_o & idx match, gives mem_result_o.
  - Else wb_we_i & idx match gives wb_data_i.
  - Else the captured register value.
- Load-use: hazard = valid_a & mem_valid_o & mem_is_load_o & mem_rd_we_o & mem_rd_idx_o!=0 & (mem_rd_idx_o==rs1_idx | mem_rd_idx_o==rs2_idx).
  - A source is checked only when it is actually used: rs1 when !sel_a_pc, rs2 always, because of store data.
- ALU drive: alu_op_o = op_a; alu_a_o = sel_a_pc ? pc : fwd_rs1; alu_b_o = sel_b_imm ? imm : fwd_rs2.
  - When valid_a=0, alu_op_o = 4'b0010 and both operands are 0.
- Advance rules:
  - stall_b = mem_valid_o & !mem_ready_i.
  - adv_a = valid_a & !hazard & !stall_b.
  - id_ready_o = !valid_a | adv_a.
  - Register A loads on id_valid_i & id_ready_o; otherwise valid_a clears on adv_a, or holds.
- Register B:
  - On adv_a it loads the ALU result, fields and fwd_rs2.
  - Else if !stall_b it loads a bubble (mem_valid_o=0).
  - Else it holds.
- Branch: taken = is_branch & (alu_zr_i ^ br_inv). redirect_valid_o is a one-cycle pulse on the cycle B loads a taken branch; it is not re-asserted while B is held.
- Branch instructions load with mem_rd_we_o=0.
- flush_i has priority over all loads: valid_a, mem_valid_o and redirect_valid_o go to 0 next cycle; data registers are don't-care.
- Simultaneous id_valid_i and flush_i: the instruction is dropped. id_ready_o is unaffected by flush.
- Latency: accepted instruction appears on mem_* 2 cycles after acceptance when no stall occurs; throughput 1 per cycle.
- Reset mid-operation clears every valid immediately (asynchronous); no partial state may leak out.

Test Plan:
- Back-to-back: ADD x1=5+7, then SUB x2=x1-2 (rs1 forwarded from B) -> mem_result_o 12 then 10, one per cycle, id_ready_o stays 1.
- Load-use: load x3 in B, next instruction uses rs1=x3 -> one bubble (mem_valid_o=0 for 1 cycle), id_ready_o=0 for 1 cycle. On the following cycle, with wb_we_i=1, wb_idx_i=3 and wb_data_i=0x55, the operand resolves to 0x55.
- Branch: pc=0x100, imm=0x20, SUB operands equal, br_inv=0 -> redirect_valid_o pulses once, redirect_pc_o=0x120. The same case with br_inv=1 gives no pulse.
- Backpressure: mem_ready_i=0 for 3 cycles with both registers full -> mem_* stable, id_ready_o=0, no instruction lost or duplicated after release.
- x0 hazard: rd=0 write followed by a use of x0 -> operand 0, no stall, no forwarding.
- Flush and reset: flush_i asserted with both registers valid -> all valids 0 next cycle. rst_n pulled low mid-stream -> outputs at reset values immediately, independent of clk.

Source files
------------

// File: rtl/ex_operand_stage.sv
// Execute-stage wrapper: ID->EX register, operand forwarding, ALU drive and EX->MEM register.
// Stalls one or more cycles on load-use hazards and on memory-stage backpressure.
module ex_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,

  input  logic                  id_valid_i,
  output logic                  id_ready_o,
  input  logic [3:0]            id_alu_op_i,
  input  logic [XLEN-1:0]       id_rs1_val_i,
  input  logic [XLEN-1:0]       id_rs2_val_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_idx_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_idx_i,
  input  logic [REG_ADDR_W-1:0] id_rd_idx_i,
  input  logic                  id_rd_we_i,
  input  logic [XLEN-1:0]       id_imm_i,
  input  logic [XLEN-1:0]       id_pc_i,
  input  logic                  id_sel_a_pc_i,
  input  logic                  id_sel_b_imm_i,
  input  logic                  id_is_load_i,
  input  logic                  id_is_branch_i,
  input  logic                  id_br_inv_i,

  output logic [3:0]            alu_op_o,
  output logic [XLEN-1:0]       alu_a_o,
  output logic [XLEN-1:0]       alu_b_o,
  input  logic [XLEN-1:0]       alu_rd_i,
  input  logic                  alu_zr_i,

  input  logic                  wb_we_i,
  input  logic [REG_ADDR_W-1:0] wb_idx_i,
  input  logic [XLEN-1:0]       wb_data_i,

  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [XLEN-1:0]       mem_result_o,
  output logic [XLEN-1:0]       mem_store_data_o,
  output logic [REG_ADDR_W-1:0] mem_rd_idx_o,
  output logic                  mem_rd_we_o,
  output logic                  mem_is_load_o,
  output logic                  redirect_valid_o,
  output logic [XLEN-1:0]       redirect_pc_o
);

  localparam logic [3:0] ALU_OP_IDLE = 4'b0010;

  logic                  valid_a;
  logic [3:0]            op_a;
  logic [XLEN-1:0]       rs1_val_a, rs2_val_a, imm_a, pc_a;
  logic [REG_ADDR_W-1:0] rs1_idx_a, rs2_idx_a, rd_idx_a;
  logic                  rd_we_a, sel_a_pc_a, sel_b_imm_a, is_load_a, is_branch_a, br_inv_a;

  logic [XLEN-1:0]       fwd_rs1, fwd_rs2;
  logic                  hazard, stall_b, adv_a, br_taken;

  // Loads in B are not forwarded: their data only exists once they reach writeback.
  function automatic logic [XLEN-1:0] forward(input logic [REG_ADDR_W-1:0] idx,
                                              input logic [XLEN-1:0]       val);
    if (idx == '0)
      return '0;
    else if (mem_valid_o && mem_rd_we_o && !mem_is_load_o && (mem_rd_idx_o == idx))
      return mem_result_o;
    else if (wb_we_i && (wb_idx_i == idx))
      return wb_data_i;
    else
      return val;
  endfunction

  always_comb begin
    fwd_rs1 = forward(rs1_idx_a, rs1_val_a);
    fwd_rs2 = forward(rs2_idx_a, rs2_val_a);

    // rs2 is always checked because stores consume it as data.
    hazard = valid_a && mem_valid_o && mem_is_load_o && mem_rd_we_o &&
             (mem_rd_idx_o != '0) &&
             ((!sel_a_pc_a && (mem_rd_idx_o == rs1_idx_a)) || (mem_rd_idx_o == rs2_idx_a));

    stall_b    = mem_valid_o && !mem_ready_i;
    adv_a      = valid_a && !hazard && !stall_b;
    id_ready_o = !valid_a || adv_a;

    alu_op_o = ALU_OP_IDLE;
    alu_a_o  = '0;
    alu_b_o  = '0;
    if (valid_a) begin
      alu_op_o = op_a;
      alu_a_o  = sel_a_pc_a  ? pc_a  : fwd_rs1;
      alu_b_o  = sel_b_imm_a ? imm_a : fwd_rs2;
    end

    br_taken = is_branch_a && (alu_zr_i ^ br_inv_a);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a     <= 1'b0;
      op_a        <= '0;
      rs1_val_a   <= '0;
      rs2_val_a   <= '0;
      imm_a       <= '0;
      pc_a        <= '0;
      rs1_idx_a   <= '0;
      rs2_idx_a   <= '0;
      rd_idx_a    <= '0;
      rd_we_a     <= 1'b0;
      sel_a_pc_a  <= 1'b0;
      sel_b_imm_a <= 1'b0;
      is_load_a   <= 1'b0;
      is_branch_a <= 1'b0;
      br_inv_a    <= 1'b0;
    end else if (flush_i) begin
      valid_a <= 1'b0;
    end else if (id_valid_i && id_ready_o) begin
      valid_a     <= 1'b1;
      op_a        <= id_alu_op_i;
      rs1_val_a   <= id_rs1_val_i;
      rs2_val_a   <= id_rs2_val_i;
      imm_a       <= id_imm_i;
      pc_a        <= id_pc_i;
      rs1_idx_a   <= id_rs1_idx_i;
      rs2_idx_a   <= id_rs2_idx_i;
      rd_idx_a    <= id_rd_idx_i;
      rd_we_a     <= id_rd_we_i;
      sel_a_pc_a  <= id_sel_a_pc_i;
      sel_b_imm_a <= id_sel_b_imm_i;
      is_load_a   <= id_is_load_i;
      is_branch_a <= id_is_branch_i;
      br_inv_a    <= id_br_inv_i;
    end else if (adv_a) begin
      valid_a <= 1'b0;
    end
  end

  // redirect_valid_o drops on every non-loading cycle so a held branch pulses only once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_valid_o      <= 1'b0;
      mem_result_o     <= '0;
      mem_store_data_o <= '0;
      mem_rd_idx_o     <= '0;
      mem_rd_we_o      <= 1'b0;
      mem_is_load_o    <= 1'b0;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else if (flush_i) begin
      mem_valid_o      <= 1'b0;
      redirect_valid_o <= 1'b0;
    end else if (adv_a) begin
      mem_valid_o      <= 1'b1;
      mem_result_o     <= alu_rd_i;
      mem_store_data_o <= fwd_rs2;
      mem_rd_idx_o     <= rd_idx_a;
      mem_rd_we_o      <= rd_we_a && !is_branch_a;
      mem_is_load_o    <= is_load_a;
      redirect_valid_o <= br_taken;
      redirect_pc_o    <= pc_a + imm_a;
    end else if (!stall_b) begin
      mem_valid_o      <= 1'b0;
      redirect_valid_o <= 1'b0;
    end else begin
      redirect_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: transaction-level pipeline model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ex_operand_stage;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] rs1v, rs2v, imm, pc;
    logic [4:0]  rs1, rs2, rd;
    logic        we, sa, sb, ld, br, inv;
  } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush_i = 1'b0;
  logic id_valid_i = 1'b0;
  logic id_ready_o;
  instr_t cur = '0;
  logic [3:0] id_alu_op_i, alu_op_o;
  logic [31:0] id_rs1_val_i, id_rs2_val_i, id_imm_i, id_pc_i;
  logic [4:0] id_rs1_idx_i, id_rs2_idx_i, id_rd_idx_i;
  logic id_rd_we_i, id_sel_a_pc_i, id_sel_b_imm_i, id_is_load_i, id_is_branch_i, id_br_inv_i;
  logic [31:0] alu_a_o, alu_b_o, alu_rd_i;
  logic alu_zr_i;
  logic wb_we_i = 1'b0;
  logic [4:0] wb_idx_i = '0;
  logic [31:0] wb_data_i = '0;
  logic mem_valid_o, mem_rd_we_o, mem_is_load_o, redirect_valid_o;
  logic mem_ready_i = 1'b1;
  logic [31:0] mem_result_o, mem_store_data_o, redirect_pc_o;
  logic [4:0] mem_rd_idx_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign id_alu_op_i    = cur.op;
  assign id_rs1_val_i   = cur.rs1v;
  assign id_rs2_val_i   = cur.rs2v;
  assign id_imm_i       = cur.imm;
  assign id_pc_i        = cur.pc;
  assign id_rs1_idx_i   = cur.rs1;
  assign id_rs2_idx_i   = cur.rs2;
  assign id_rd_idx_i    = cur.rd;
  assign id_rd_we_i     = cur.we;
  assign id_sel_a_pc_i  = cur.sa;
  assign id_sel_b_imm_i = cur.sb;
  assign id_is_load_i   = cur.ld;
  assign id_is_branch_i = cur.br;
  assign id_br_inv_i    = cur.inv;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  assign alu_rd_i = alu_f(alu_op_o, alu_a_o, alu_b_o);
  assign alu_zr_i = (alu_rd_i == 32'd0);

  ex_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_alu_op_i(id_alu_op_i),
    .id_rs1_val_i(id_rs1_val_i), .id_rs2_val_i(id_rs2_val_i),
    .id_rs1_idx_i(id_rs1_idx_i), .id_rs2_idx_i(id_rs2_idx_i), .id_rd_idx_i(id_rd_idx_i),
    .id_rd_we_i(id_rd_we_i), .id_imm_i(id_imm_i), .id_pc_i(id_pc_i),
    .id_sel_a_pc_i(id_sel_a_pc_i), .id_sel_b_imm_i(id_sel_b_imm_i),
    .id_is_load_i(id_is_load_i), .id_is_branch_i(id_is_branch_i), .id_br_inv_i(id_br_inv_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_rd_i(alu_rd_i), .alu_zr_i(alu_zr_i),
    .wb_we_i(wb_we_i), .wb_idx_i(wb_idx_i), .wb_data_i(wb_data_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_result_o(mem_result_o),
    .mem_store_data_o(mem_store_data_o), .mem_rd_idx_o(mem_rd_idx_o),
    .mem_rd_we_o(mem_rd_we_o), .mem_is_load_o(mem_is_load_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: slot A holds an accepted instruction record, slot B holds its computed outcome.
  bit     ma_v;
  instr_t ma;
  bit     mb_v, mb_we, mb_ld, mb_rv;
  logic [31:0] mb_res, mb_st, mb_rpc;
  logic [4:0]  mb_rd;
  bit          e_rdy, e_adv, e_stall;
  logic [3:0]  e_op;
  logic [31:0] e_a, e_b;

  function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] v);
    if (idx == 5'd0) return 32'd0;
    if (mb_v && mb_we && !mb_ld && mb_rd == idx) return mb_res;
    if (wb_we_i && wb_idx_i == idx) return wb_data_i;
    return v;
  endfunction

  task automatic model_reset();
    ma_v = 0; mb_v = 0; mb_rv = 0; mb_we = 0; mb_ld = 0;
  endtask

  task automatic sample();
    bit haz;
    @(negedge clk);
    haz = ma_v && mb_v && mb_ld && mb_we && mb_rd != 5'd0 &&
          ((!ma.sa && mb_rd == ma.rs1) || mb_rd == ma.rs2);
    e_stall = mb_v && !mem_ready_i;
    e_adv   = ma_v && !haz && !e_stall;
    e_rdy   = !ma_v || e_adv;
    e_op    = ma_v ? ma.op : 4'd2;
    e_a     = !ma_v ? 32'd0 : (ma.sa ? ma.pc  : m_fwd(ma.rs1, ma.rs1v));
    e_b     = !ma_v ? 32'd0 : (ma.sb ? ma.imm : m_fwd(ma.rs2, ma.rs2v));
    chk("id_ready", id_ready_o, e_rdy);
    chk("alu_op", alu_op_o, e_op);
    chk("alu_a", alu_a_o, e_a);
    chk("alu_b", alu_b_o, e_b);
    chk("mem_valid", mem_valid_o, mb_v);
    chk("redirect_valid", redirect_valid_o, mb_rv);
    if (mb_v) begin
      chk("mem_result", mem_result_o, mb_res);
      chk("mem_store", mem_store_data_o, mb_st);
      chk("mem_rd_idx", mem_rd_idx_o, mb_rd);
      chk("mem_flags", {mem_rd_we_o, mem_is_load_o}, {mb_we, mb_ld});
    end
    if (mb_rv) chk("redirect_pc", redirect_pc_o, mb_rpc);
  endtask

  task automatic advance();
    logic [31:0] res, st;
    if (flush_i) begin
      ma_v = 0; mb_v = 0; mb_rv = 0;
    end else begin
      res = alu_f(e_op, e_a, e_b);
      st  = m_fwd(ma.rs2, ma.rs2v);
      if (e_adv) begin
        mb_v = 1; mb_res = res; mb_st = st; mb_rd = ma.rd;
        mb_we = ma.we && !ma.br; mb_ld = ma.ld;
        mb_rv = ma.br && ((res == 32'd0) ^ ma.inv);
        mb_rpc = ma.pc + ma.imm;
      end else begin
        if (!e_stall) mb_v = 0;
        mb_rv = 0;
      end
      if (id_valid_i && e_rdy) begin ma_v = 1; ma = cur; end
      else if (e_adv) ma_v = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic [4:0] rs1, input logic [31:0] rs1v,
                                input logic [4:0] rs2, input logic [31:0] rs2v, input logic [4:0] rd,
                                input logic we, input logic [31:0] imm, input logic sb);
    instr_t t = '0;
    t.op = op; t.rs1 = rs1; t.rs1v = rs1v; t.rs2 = rs2; t.rs2v = rs2v;
    t.rd = rd; t.we = we; t.imm = imm; t.sb = sb;
    return t;
  endfunction

  task automatic idle(input int n);
    id_valid_i = 0; flush_i = 0; mem_ready_i = 1; wb_we_i = 0;
    for (int i = 0; i < n; i++) begin sample(); advance(); end
  endtask

  function automatic logic [31:0] rval();
    return ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
  endfunction

  initial begin
    model_reset();
    #12;
    chk("rst_id_ready", id_ready_o, 1);
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_redirect", redirect_valid_o, 0);
    chk("rst_flags", {mem_rd_we_o, mem_is_load_o}, 2'b00);
    chk("rst_result", mem_result_o, 0);
    chk("rst_alu_op", alu_op_o, 4'b0010);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Back-to-back ADD x1=5+7, SUB x2=x1-2 with x1 forwarded from B.
    id_valid_i = 1; cur = mk(4'd0, 5'd4, 32'd5, 5'd5, 32'd7, 5'd1, 1, 0, 0);
    sample(); advance();
    cur = mk(4'd1, 5'd1, 32'd0, 5'd0, 32'd0, 5'd2, 1, 32'd2, 1);
    sample(); chk("b2b_ready", id_ready_o, 1); advance();
    id_valid_i = 0;
    sample(); chk("b2b_first", mem_result_o, 32'd12); chk("b2b_valid", mem_valid_o, 1); advance();
    sample(); chk("b2b_second", mem_result_o, 32'd10); advance();
    idle(2);

    // Load-use on x3, then x3 resolved from writeback.
    id_valid_i = 1; cur = mk(4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 1, 32'h40, 1); cur.ld = 1;
    sample(); advance();
    cur = mk(4'd0, 5'd3, 32'd9, 5'd0, 32'd0, 5'd6, 1, 32'd0, 1);
    sample(); advance();
    id_valid_i = 0;
    sample(); chk("lu_stall_ready", id_ready_o, 0); chk("lu_load_in_b", mem_is_load_o, 1); advance();
    wb_we_i = 1; wb_idx_i = 5'd3; wb_data_i = 32'h55;
    sample(); chk("lu_bubble", mem_valid_o, 0); chk("lu_wb_fwd", alu_a_o, 32'h55); advance();
    wb_we_i = 0;
    sample(); chk("lu_result", mem_result_o, 32'h55); advance();
    idle(2);

    // Taken branch (equal operands, br_inv=0), then the inverted case.
    for (int inv = 0; inv < 2; inv++) begin
      id_valid_i = 1;
      cur = mk(4'd1, 5'd6, 32'd9, 5'd7, 32'd9, 5'd8, 1, 32'h20, 0);
      cur.pc = 32'h100; cur.br = 1; cur.inv = inv[0];
      sample(); advance();
      id_valid_i = 0;
      sample(); advance();
      sample();
      chk("br_pulse", redirect_valid_o, (inv == 0) ? 32'd1 : 32'd0);
      if (inv == 0) chk("br_target", redirect_pc_o, 32'h120);
      chk("br_no_rd_we", mem_rd_we_o, 0);
      advance();
      sample(); chk("br_single_pulse", redirect_valid_o, 0); advance();
    end
    idle(1);

    // Backpressure: three cycles of mem_ready_i=0 with both registers full.
    id_valid_i = 1; cur = mk(4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 0, 32'd11, 1);
    sample(); advance();
    cur.imm = 32'd21;
    sample(); advance();
    cur.imm = 32'd31; mem_ready_i = 0;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("bp_hold", mem_result_o, 32'd11); chk("bp_ready", id_ready_o, 0); advance();
    end
    mem_ready_i = 1;
    sample(); chk("bp_release", id_ready_o, 1); advance();
    id_valid_i = 0;
    sample(); chk("bp_second", mem_result_o, 32'd21); advance();
    sample(); chk("bp_third", mem_result_o, 32'd31); advance();
    sample(); chk("bp_drained", mem_valid_o, 0); advance();
    idle(1);

    // x0: load to x0 then a use of x0 must neither stall nor forward.
    id_valid_i = 1; cur = mk(4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 1, 32'h77, 1); cur.ld = 1;
    sample(); advance();
    cur = mk(4'd0, 5'd0, 32'h99, 5'd0, 32'h99, 5'd10, 1, 32'd0, 0);
    sample(); advance();
    id_valid_i = 0; wb_we_i = 1; wb_idx_i = 5'd0; wb_data_i = 32'h33;
    sample(); chk("x0_no_stall", id_ready_o, 1); chk("x0_a", alu_a_o, 0); chk("x0_b", alu_b_o, 0); advance();
    idle(2);

    // Flush with both registers valid and a new instruction offered at the same time.
    id_valid_i = 1; cur = mk(4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd11, 1, 32'd1, 1);
    sample(); advance();
    sample(); advance();
    flush_i = 1;
    sample(); chk("fl_before", mem_valid_o, 1); advance();
    flush_i = 0; id_valid_i = 0;
    sample(); chk("fl_b_cleared", mem_valid_o, 0); chk("fl_a_cleared", alu_op_o, 4'b0010); advance();
    sample(); chk("fl_dropped", mem_valid_o, 0); advance();

    // Asynchronous reset mid-stream.
    id_valid_i = 1; cur = mk(4'd0, 5'd1, 32'd3, 5'd2, 32'd4, 5'd12, 1, 32'd0, 0); cur.br = 1; cur.inv = 1;
    sample(); advance();
    sample(); advance();
    #2 rst_n = 0;
    #1;
    chk("arst_valid", mem_valid_o, 0);
    chk("arst_redirect", redirect_valid_o, 0);
    chk("arst_ready", id_ready_o, 1);
    chk("arst_alu_op", alu_op_o, 4'b0010);
    chk("arst_flags", {mem_rd_we_o, mem_is_load_o}, 2'b00);
    model_reset();
    id_valid_i = 0;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      id_valid_i  = ($urandom_range(0, 3) != 0);
      cur.op      = 4'($urandom_range(0, 5));
      cur.rs1     = 5'($urandom_range(0, 3));
      cur.rs2     = 5'($urandom_range(0, 3));
      cur.rd      = 5'($urandom_range(0, 3));
      cur.rs1v    = rval();
      cur.rs2v    = rval();
      cur.imm     = rval();
      cur.pc      = $urandom;
      cur.we      = ($urandom_range(0, 3) != 0);
      cur.sa      = ($urandom_range(0, 3) == 0);
      cur.sb      = ($urandom_range(0, 2) == 0);
      cur.ld      = ($urandom_range(0, 3) == 0);
      cur.br      = ($urandom_range(0, 4) == 0);
      cur.inv     = 1'($urandom_range(0, 1));
      flush_i     = ($urandom_range(0, 24) == 0);
      mem_ready_i = ($urandom_range(0, 3) != 0);
      wb_we_i     = 1'($urandom_range(0, 1));
      wb_idx_i    = 5'($urandom_range(0, 3));
      wb_data_i   = rval();
      sample();
      advance();
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
